alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
alu_mc is a parametrised, multi-cycle ALU for the multi-cycle and pipelined MIPS datapaths. It extends the basic five-function ALU in three ways:
- WIDTH-generic operands.
- A 4-bit opcode covering logic, arithmetic, signed and unsigned compare, and shifts.
- Iterative unsigned multiply and divide, with a HI result.

Operands enter through a valid/ready handshake. The result is held on a valid/ready output until the consumer accepts it.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands/opcode present
in_ready  out  1  block can accept (combinational: state==IDLE)
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shifts use b[SHW-1:0] as amount, a as data)
f  in  4  opcode
out_valid  out  1  result registers valid
out_ready  in  1  consumer accepts result
y  out  WIDTH  primary result (MULTU: low word; DIVU: quotient)
hi  out  WIDTH  MULTU: high word; DIVU: remainder; else 0
zero  out  1  y==0, registered with y
ovf  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLTU, 6 SUB, 7 SLT.
  - 8 SLL, 9 SRL, 10 SRA.
  - 12 MULTU, 13 DIVU.
  - 11/14/15 illegal: y=0, hi=0, ovf=0, zero=1, single-cycle.
- Accept occurs when in_valid && in_ready. a, b and f are captured at accept; input changes afterwards have no effect.
- FSM states:
  - IDLE: accept goes to DONE for single-cycle ops, MUL for 12, DIV for 13.
  - MUL: runs WIDTH iterations, then DONE.
  - DIV: runs WIDTH iterations, then DONE.
  - DONE: out_valid=1; out_ready goes to IDLE.
- Latency:
  - Single-cycle ops: out_valid in cycle accept+1.
  - MULTU/DIVU: out_valid in cycle accept+WIDTH+1.
- Throughput: a new accept is only possible the cycle after DONE is consumed. in_ready is 0 in MUL, DIV and DONE.
- y, hi, zero and ovf stay stable for the whole of DONE. They keep their last values in IDLE until the next result is written.
- ADD/SUB arithmetic:
  - Results are modulo 2^WIDTH.
  - ovf = operand signs equal (ADD), or differ (SUB), and the result sign differs from a.
- SLT is the true signed compare (a<b): sum sign XOR overflow of a-b. SLTU is the unsigned compare. Both give y ∈ {0,1}.
- Shifts: SRA replicates a[WIDTH-1]. Shift amount 0 gives y=a.
- MULTU: shift-add, one bit of b per cycle, 2*WIDTH accumulator. {hi,y} = a*b unsigned.
- DIVU: restoring division, one quotient bit per cycle.
  - Normal case: y=a/b, hi=a%b.
  - Divide by zero: y = all ones, hi = a, completes after the normal WIDTH cycles, ovf=0.
- zero is computed from the final y value written to the result register, never from intermediate accumulator values.
- Reset (asserted at any time, including mid-MUL/DIV): state goes to IDLE immediately and all output registers clear (out_valid=0, y=0, hi=0, zero=0, ovf=0). The in-flight operation is discarded. in_ready=1 once reset_n deasserts.
- out_valid held with out_ready=0: DONE persists indefinitely and outputs stay unchanged.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum (4-bit opcode values above).
  - alu_state_e enum (IDLE, MUL, DIV, DONE).
  - Opcode-class helper function is_multicycle(f).
- One sub-module, alu_muldiv_iter: the shared iterative datapath.
  - Contents: accumulator, shift registers, iteration counter.
  - Inputs: start, op, a, b.
  - Outputs: done pulse, lo, hi.
- alu_mc keeps the FSM, handshake, single-cycle combinational ops and the result registers.

Test Plan:
1. WIDTH=32, ADD a=0x7FFFFFFF b=1 -> out_valid at accept+1: y=0x80000000, ovf=1, zero=0. SUB a=5 b=5 -> y=0, zero=1, ovf=0.
2. SLT a=0xFFFFFFFF b=1 -> y=1. SLTU with the same operands -> y=0. SLT a=0x80000000 b=0x7FFFFFFF -> y=1.
3. SRA a=0x80000000 b=31 -> y=0xFFFFFFFF. SRL with the same operands -> y=1. SLL a=1 b=0 -> y=1.
4. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept: hi=0xFFFFFFFE, y=0x00000001. in_ready=0 throughout.
5. DIVU a=100 b=7 -> y=14, hi=2. DIVU a=100 b=0 -> y=0xFFFFFFFF, hi=100, latency 33.
6. Handshake and reset:
   - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_valid ignored.
   - Assert reset_n=0 at iteration 12 of a MULTU -> out_valid=0, y=hi=0 immediately.
   - After release, ADD 2+3 -> y=5 at accept+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU.
//   alu_op_e      : 4-bit opcode encoding (11, 14 and 15 are illegal)
//   alu_state_e   : control FSM states
//   is_multicycle : true for opcodes served by the iterative datapath
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'd0,
    OpOr    = 4'd1,
    OpAdd   = 4'd2,
    OpXor   = 4'd3,
    OpNor   = 4'd4,
    OpSltu  = 4'd5,
    OpSub   = 4'd6,
    OpSlt   = 4'd7,
    OpSll   = 4'd8,
    OpSrl   = 4'd9,
    OpSra   = 4'd10,
    OpMultu = 4'd12,
    OpDivu  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } alu_state_e;

  function automatic logic is_multicycle(logic [3:0] f);
    return (f == OpMultu) || (f == OpDivu);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide datapath, one bit per cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load operands and begin (op_div_i selects DIVU, else MULTU)
//   a_i, b_i      : operands, sampled only on start_i
//   done_o        : high in the final iteration cycle; lo_o/hi_o are the final
//                   result in that same cycle
//   lo_o, hi_o    : MULTU low/high product word; DIVU quotient/remainder
// Multiply: acc = {hi, lo}, lo starts as b; each step adds a to hi when
// lo[0] is set, then shifts the whole accumulator right one place.
// Divide (restoring): acc = {rem, quo}, quo starts as a; each step shifts
// one dividend bit into rem and subtracts the divisor when it fits.
// A zero divisor always "fits", which yields quo = all ones and rem = a.
module alu_muldiv_iter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] lo_o,
  output logic [Width-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [2*Width-1:0] acc_q, acc_step;
  logic [Width-1:0]   opnd_q;
  logic               div_q;
  logic               busy_q;
  logic [CntW-1:0]    cnt_q;

  logic [Width:0]     mul_sum;
  logic [Width:0]     rem_shift;
  logic [Width-1:0]   rem_sub;
  logic               div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = acc_q[2*Width-1:Width-1];
    div_ge    = rem_shift >= {1'b0, opnd_q};
    // The remainder after a successful subtract is below the divisor, so
    // the low Width bits carry the full result.
    rem_sub   = rem_shift[Width-1:0] - opnd_q;
    if (div_q) begin
      acc_step = {(div_ge ? rem_sub : rem_shift[Width-1:0]), acc_q[Width-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[Width-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == LastCnt);
  assign lo_o   = acc_step[Width-1:0];
  assign hi_o   = acc_step[2*Width-1:Width];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      acc_q  <= op_div_i ? {{Width{1'b0}}, a_i} : {{Width{1'b0}}, b_i};
      opnd_q <= op_div_i ? b_i : a_i;
      div_q  <= op_div_i;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on operands and result.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, f              : operands and 4-bit opcode, captured at accept
//   out_valid/out_ready  : result handshake (out_valid only in DONE)
//   y, hi                : result; hi is MULTU high word / DIVU remainder
//   zero, ovf            : y == 0; signed overflow for ADD/SUB
// Single-cycle ops are evaluated from the live inputs and written to the
// result registers on the accept edge. MULTU/DIVU hand the operands to
// the iterative datapath and write its result on its final iteration.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e state_q, state_d;

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  logic [WIDTH-1:0] sc_y;
  logic             sc_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic             ovf_add, ovf_sub;
  logic [SHW-1:0]   shamt;

  assign in_ready   = (state_q == StIdle);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_multicycle(f);

  // Single-cycle combinational ops.
  always_comb begin
    shamt   = b[SHW-1:0];
    sum     = a + b;
    diff    = a - b;
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    sc_y    = '0;
    sc_ovf  = 1'b0;
    case (f)
      OpAnd:  sc_y = a & b;
      OpOr:   sc_y = a | b;
      OpAdd:  begin
        sc_y   = sum;
        sc_ovf = ovf_add;
      end
      OpXor:  sc_y = a ^ b;
      OpNor:  sc_y = ~(a | b);
      OpSltu: sc_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OpSub:  begin
        sc_y   = diff;
        sc_ovf = ovf_sub;
      end
      // Sign of a-b corrected by overflow gives the true signed a<b.
      OpSlt:  sc_y = {{(WIDTH-1){1'b0}}, (diff[WIDTH-1] ^ ovf_sub)};
      OpSll:  sc_y = a << shamt;
      OpSrl:  sc_y = a >> shamt;
      OpSra:  sc_y = WIDTH'($signed(a) >>> shamt);
      default: begin
        sc_y   = '0;
        sc_ovf = 1'b0;
      end
    endcase
  end

  // Next-state and result-register load.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (f == OpMultu) begin
            state_d = StMul;
          end else if (f == OpDivu) begin
            state_d = StDiv;
          end else begin
            state_d = StDone;
            y_d     = sc_y;
            hi_d    = '0;
            zero_d  = (sc_y == '0);
            ovf_d   = sc_ovf;
          end
        end
      end
      StMul, StDiv: begin
        if (iter_done) begin
          state_d = StDone;
          y_d     = iter_lo;
          hi_d    = iter_hi;
          zero_d  = (iter_lo == '0);
          ovf_d   = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  alu_muldiv_iter #(
    .Width(WIDTH)
  ) u_iter (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .start_i (iter_start),
    .op_div_i(f == OpDivu),
    .a_i     (a),
    .b_i     (b),
    .done_o  (iter_done),
    .lo_o    (iter_lo),
    .hi_o    (iter_hi)
  );

  assign out_valid = (state_q == StDone);
  assign y         = y_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  f_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic [31:0] hi;
  logic        zero;
  logic        ovf;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_mc #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .f        (f_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .hi       (hi),
    .zero     (zero),
    .ovf      (ovf)
  );

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic [31:0] ehi, input logic ez,
                         input logic eo, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.y = ey; v.hi = ehi; v.zero = ez; v.ovf = eo; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference model from the opcode definitions, plain integer arithmetic.
  function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ey, output logic [31:0] ehi,
                                output logic eo, output int lat);
    longint sa, sb, r;
    longint maxs, mins;
    logic [63:0] p;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxs = 64'sd2147483647;
    mins = -64'sd2147483648;
    sh = b[4:0];
    ey = '0; ehi = '0; eo = 1'b0; lat = 1;
    case (f)
      4'd0: ey = a & b;
      4'd1: ey = a | b;
      4'd2: begin r = sa + sb; ey = a + b; eo = (r > maxs) || (r < mins); end
      4'd3: ey = a ^ b;
      4'd4: ey = ~(a | b);
      4'd5: ey = (a < b) ? 32'd1 : 32'd0;
      4'd6: begin r = sa - sb; ey = a - b; eo = (r > maxs) || (r < mins); end
      4'd7: ey = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: ey = a << sh;
      4'd9: ey = a >> sh;
      4'd10: ey = 32'($signed(a) >>> sh);
      4'd12: begin p = 64'(a) * 64'(b); ey = p[31:0]; ehi = p[63:32]; lat = 33; end
      4'd13: begin
        lat = 33;
        if (b == 0) begin ey = 32'hFFFF_FFFF; ehi = a; end
        else begin ey = a / b; ehi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Issue one operation, wait for the result, consume it.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ry, output logic [31:0] rhi, output logic rz,
                        output logic ro, output int lat, output logic rdy_seen,
                        output logic tmo);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; a_i = a; b_i = b; f_i = f;
    @(posedge clk);
    #1;
    // Scramble inputs to prove they were captured at accept.
    in_valid = 1'b0; a_i = $urandom; b_i = $urandom; f_i = 4'($urandom);
    lat = 0; rdy_seen = 1'b0; tmo = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        tmo = 1'b0;
        break;
      end
      if (in_ready) rdy_seen = 1'b1;
    end
    ry = y; rhi = hi; rz = zero; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ry, rhi, ey, ehi;
    logic rz, ro, eo, rdy, tmo;
    int lat, elat, n;

    add_vec(4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1);
    add_vec(4'd6, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    add_vec(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    add_vec(4'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd9, 32'h8000_0000, 32'd31, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd8, 32'd1, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    add_vec(4'd13, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
    add_vec(4'd13, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b0, 33);
    add_vec(4'd11, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    add_vec(4'd15, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    add_vec(4'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1);
    add_vec(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    add_vec(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd4, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1);
    add_vec(4'd12, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'd1, 1'b0, 1'b0, 33);
    add_vec(4'd13, 32'd6, 32'd7, 32'd0, 32'd6, 1'b1, 1'b0, 33);

    // Reset state.
    repeat (3) @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_y", y, 32'd0);
    chk32("rst_hi", hi, 32'd0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    reset_n = 1'b1;
    #1 chk1("rst_in_ready", in_ready, 1'b1);

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, ry, rhi, rz, ro, lat, rdy, tmo);
      chk1($sformatf("v%0d_timeout", i), tmo, 1'b0);
      chk32($sformatf("v%0d_y", i), ry, vecs[i].y);
      chk32($sformatf("v%0d_hi", i), rhi, vecs[i].hi);
      chk1($sformatf("v%0d_zero", i), rz, vecs[i].zero);
      chk1($sformatf("v%0d_ovf", i), ro, vecs[i].ovf);
      chk32($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk1($sformatf("v%0d_in_ready_busy", i), rdy, 1'b0);
    end

    // Randomized against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] f;
      logic [31:0] a, b;
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 8));
      if ($urandom_range(0, 5) == 0) a = b;
      model(f, a, b, ey, ehi, eo, elat);
      run_op(f, a, b, ry, rhi, rz, ro, lat, rdy, tmo);
      chk1($sformatf("r%0d_timeout", i), tmo, 1'b0);
      chk32($sformatf("r%0d_y f=%0d a=%h b=%h", i, f, a, b), ry, ey);
      chk32($sformatf("r%0d_hi f=%0d a=%h b=%h", i, f, a, b), rhi, ehi);
      chk1($sformatf("r%0d_zero", i), rz, (ey == 32'd0));
      chk1($sformatf("r%0d_ovf", i), ro, eo);
      chk32($sformatf("r%0d_lat", i), 32'(lat), 32'(elat));
    end

    // Hold DONE with out_ready low while in_valid presents other operands.
    @(negedge clk);
    in_valid = 1'b1; f_i = 4'd2; a_i = 32'd10; b_i = 32'd20;
    @(posedge clk);
    #1 a_i = 32'd1; b_i = 32'd1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("hold_reached_done", out_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk1($sformatf("hold%0d_valid", k), out_valid, 1'b1);
      chk1($sformatf("hold%0d_in_ready", k), in_ready, 1'b0);
      chk32($sformatf("hold%0d_y", k), y, 32'd30);
      chk1($sformatf("hold%0d_zero", k), zero, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset in the middle of a MULTU.
    @(negedge clk);
    in_valid = 1'b1; f_i = 4'd12; a_i = 32'hDEAD_BEEF; b_i = 32'h0123_4567;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk1("mid_mul_busy", in_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk32("mid_rst_y", y, 32'd0);
    chk32("mid_rst_hi", hi, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk1("post_rst_in_ready", in_ready, 1'b1);
    run_op(4'd2, 32'd2, 32'd3, ry, rhi, rz, ro, lat, rdy, tmo);
    chk1("post_rst_timeout", tmo, 1'b0);
    chk32("post_rst_add_y", ry, 32'd5);
    chk32("post_rst_add_lat", 32'(lat), 32'd1);
    // The aborted MULTU must not surface later.
    repeat (40) @(negedge clk);
    chk1("no_stale_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
